reg_access_arbiter: RTL and testbench

- Shares the 8-bit register bank (write/increment/clear strobes plus a common BusOut data path) between NREQ requesters, such as the control FSM, the ALU writeback and the debug port.
- Each requester posts one command (WRITE, INC or CLR) aimed at one register, with write data.
- The arbiter picks one requester round-robin and issues exactly one strobe to the target register for one cycle.
- It then returns an ack with the target register's zero flag as it stands after the operation.

---
 rtl/reg_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 32 +++
 rtl/reg_access_arbiter.sv | 141 ++++++++++++++
 tb/tb_reg_access_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types for the register-bank access arbiter: command codes and FSM states.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_INC   = 2'b10,
    CMD_CLR   = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational requester picker: round-robin from rr_ptr, or lowest-index-wins
// when ARB_FIXED_PRIO_EN is defined (rr_ptr then ignored).
module rr_picker #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) gnt_idx = IW'(i);
`else
    // Scan backwards so the candidate closest to rr_ptr is the last one kept.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) gnt_idx = IW'(j);
    end
`endif
    if (|req) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates NREQ requesters onto one register bank, one strobe per command, then acks
// with the target's zero flag. ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int NREG = 4,
  parameter  int W    = 8,
  localparam int SW   = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] cmd,
  input  logic [SW*NREQ-1:0] sel,
  input  logic [W*NREQ-1:0] wdata,
  input  logic [NREG-1:0]   reg_z,
  output logic [NREG-1:0]   reg_wen,
  output logic [NREG-1:0]   reg_inc,
  output logic [NREG-1:0]   reg_clr,
  output logic [W-1:0]      bus_out,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_z,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   id_q, id_d;
  cmd_t            cmd_q, cmd_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_RESP)
      rr_ptr_d = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!RST) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          id_d    = gnt_idx;
          cmd_d   = cmd_t'(cmd[int'(gnt_idx)*2 +: 2]);
          sel_d   = sel[int'(gnt_idx)*SW +: SW];
          wdata_d = wdata[int'(gnt_idx)*W +: W];
          err_d   = (cmd_d == CMD_NOP) || (int'(sel_d) >= NREG);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RST) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      cmd_q   <= CMD_NOP;
      sel_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode only flops, so nothing here glitches with requester inputs.
  always_comb begin
    reg_wen = '0;
    reg_inc = '0;
    reg_clr = '0;
    bus_out = '0;
    ack     = '0;
    rsp_z   = 1'b0;
    rsp_err = 1'b0;
    if (state_q == S_ISSUE) begin
      if (cmd_q == CMD_WRITE) bus_out = wdata_q;
      for (int i = 0; i < NREG; i++) begin
        if (!err_q && int'(sel_q) == i) begin
          case (cmd_q)
            CMD_WRITE: reg_wen[i] = 1'b1;
            CMD_INC:   reg_inc[i] = 1'b1;
            CMD_CLR:   reg_clr[i] = 1'b1;
            default:   ;
          endcase
        end
      end
    end
    if (state_q == S_RESP) begin
      rsp_err = err_q;
      for (int i = 0; i < NREQ; i++)
        if (int'(id_q) == i) ack[i] = 1'b1;
      for (int i = 0; i < NREG; i++)
        if (int'(sel_q) == i) rsp_z = reg_z[i];
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter with a behavioural register bank (NREG=5 so
// out-of-range selects are encodable).
module tb_reg_access_arbiter;
  import reg_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int NREG = 5;
  localparam int W    = 8;
  localparam int SW   = 3;

  logic               Clk = 1'b0;
  logic               RST = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [2*NREQ-1:0]  cmd_v = '0;
  logic [SW*NREQ-1:0] sel_v = '0;
  logic [W*NREQ-1:0]  wdata_v = '0;
  logic [NREG-1:0]    reg_z;
  logic [NREG-1:0]    reg_wen, reg_inc, reg_clr;
  logic [W-1:0]       bus_out;
  logic [NREQ-1:0]    ack;
  logic               rsp_z, rsp_err, busy;

  reg_access_arbiter #(.NREQ(NREQ), .NREG(NREG), .W(W)) dut (
    .Clk(Clk), .RST(RST), .req(req), .cmd(cmd_v), .sel(sel_v), .wdata(wdata_v),
    .reg_z(reg_z), .reg_wen(reg_wen), .reg_inc(reg_inc), .reg_clr(reg_clr),
    .bus_out(bus_out), .ack(ack), .rsp_z(rsp_z), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { int kind; int sel; logic [W-1:0] data; } stb_t;
  typedef struct { int id; logic z; logic err; } ack_t;
  stb_t stb_q[$];
  ack_t ack_q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] start_val(input int i);
    return (i == 1) ? 8'd34 : 8'd0;
  endfunction

  // Behavioural bank driven by the DUT strobes, plus the bench's reference copy.
  logic [W-1:0] bank [NREG];
  logic [W-1:0] refb [NREG];
  initial for (int i = 0; i < NREG; i++) begin bank[i] = start_val(i); refb[i] = start_val(i); end

  always @(posedge Clk)
    for (int i = 0; i < NREG; i++) begin
      if (reg_wen[i])      bank[i] <= bus_out;
      else if (reg_inc[i]) bank[i] <= bank[i] + 8'd1;
      else if (reg_clr[i]) bank[i] <= start_val(i);
    end

  always_comb for (int i = 0; i < NREG; i++) reg_z[i] = (bank[i] == '0);

  // Monitor: pops expectations whenever a strobe or ack appears.
  stb_t me; ack_t ma; int akind, asel, aid;
  always @(negedge Clk) begin
    if ($countones({reg_wen, reg_inc, reg_clr}) > 1 || $countones(ack) > 1) begin
      checks++; errors++;
      $display("FAIL onehot wen=%b inc=%b clr=%b ack=%b required at most one bit", reg_wen, reg_inc, reg_clr, ack);
    end
    if (|{reg_wen, reg_inc, reg_clr}) begin
      checks++;
      akind = |reg_wen ? 1 : |reg_inc ? 2 : 3;
      asel = -1;
      for (int i = 0; i < NREG; i++) if (reg_wen[i] | reg_inc[i] | reg_clr[i]) asel = i;
      if (stb_q.size() == 0) begin
        errors++;
        $display("FAIL strobe unexpected kind=%0d sel=%0d required none", akind, asel);
      end else begin
        me = stb_q.pop_front();
        if (akind != me.kind || asel != me.sel || bus_out != me.data) begin
          errors++;
          $display("FAIL strobe got kind=%0d sel=%0d bus=%0d required kind=%0d sel=%0d bus=%0d",
                   akind, asel, bus_out, me.kind, me.sel, me.data);
        end
      end
    end
    if (|ack) begin
      checks++;
      aid = 0;
      for (int i = 0; i < NREQ; i++) if (ack[i]) aid = i;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack unexpected id=%0d required none", aid);
      end else begin
        ma = ack_q.pop_front();
        if (aid != ma.id || rsp_z != ma.z || rsp_err != ma.err) begin
          errors++;
          $display("FAIL ack got id=%0d z=%0b err=%0b required id=%0d z=%0b err=%0b",
                   aid, rsp_z, rsp_err, ma.id, ma.z, ma.err);
        end
      end
    end
  end

  int cur_c [NREQ];
  int cur_s [NREQ];
  logic [W-1:0] cur_d [NREQ];

  task automatic expect_cmd(input int id, input int c, input int s, input logic [W-1:0] d, input bit with_ack);
    bit err;
    stb_t e;
    ack_t a;
    err = (c == 0) || (s >= NREG);
    if (!err) begin
      e.kind = c; e.sel = s; e.data = (c == 1) ? d : 8'h00;
      stb_q.push_back(e);
      case (c)
        1: refb[s] = d;
        2: refb[s] = refb[s] + 8'd1;
        default: refb[s] = start_val(s);
      endcase
    end
    a.id = id; a.err = err;
    a.z = (s < NREG) ? (refb[s] == '0) : 1'b0;
    if (with_ack) ack_q.push_back(a);
  endtask

  task automatic set_req(input int id, input int c, input int s, input logic [W-1:0] d);
    cur_c[id] = c; cur_s[id] = s; cur_d[id] = d;
    cmd_v[id*2 +: 2]    = 2'(c);
    sel_v[id*SW +: SW]  = SW'(s);
    wdata_v[id*W +: W]  = d;
    req[id] = 1'b1;
  endtask

  // One isolated command from an idle DUT: ack must land exactly 2 cycles later.
  task automatic do_cmd(input int id, input int c, input int s, input logic [W-1:0] d);
    int lat;
    bit got;
    expect_cmd(id, c, s, d, 1'b1);
    set_req(id, c, s, d);
    got = 1'b0;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge Clk);
      if (ack[id]) begin got = 1'b1; break; end
    end
    req[id] = 1'b0;
    checks++;
    if (!got || lat != 2) begin
      errors++;
      $display("FAIL latency id=%0d acked=%0b cycles=%0d required 2", id, got, lat);
    end
    @(negedge Clk);
  endtask

  // Requests already raised and held; expects n grants in the given order, 3 cycles apart.
  task automatic run_held(input int n, input int o0, input int o1, input int o2, input int o3);
    int ord [4];
    int t, last;
    bit got;
    ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
    for (int k = 0; k < n; k++) expect_cmd(ord[k], cur_c[ord[k]], cur_s[ord[k]], cur_d[ord[k]], 1'b1);
    t = 0; last = -1;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int w = 0; w < 8; w++) begin
        @(negedge Clk); t++;
        if (|ack) begin got = 1'b1; break; end
      end
      checks++;
      if (!got || (last >= 0 && t - last != 3)) begin
        errors++;
        $display("FAIL spacing grant=%0d acked=%0b gap=%0d required 3", k, got, t - last);
      end
      last = t;
    end
    req = '0;
    @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    checks++;
    if ({reg_wen, reg_inc, reg_clr, bus_out, ack, rsp_z, rsp_err, busy} != '0) begin
      errors++;
      $display("FAIL reset_outputs got wen=%b inc=%b clr=%b bus=%0d ack=%b busy=%b required all 0",
               reg_wen, reg_inc, reg_clr, bus_out, ack, busy);
    end
    RST = 1'b1;
    @(negedge Clk);

    do_cmd(0, 1, 2, 8'd62);           // single write
    do_cmd(1, 1, 1, 8'hFF);           // preload reg1
    do_cmd(1, 2, 1, 8'h00);           // INC wraps to 0 -> z=1
    do_cmd(1, 3, 1, 8'h00);           // CLR to 34 -> z=0
    do_cmd(2, 0, 0, 8'h00);           // NOP -> err
    do_cmd(0, 1, 5, 8'h11);           // bad sel -> err, z=0
    do_cmd(1, 2, 7, 8'h00);

    RST = 1'b0;
    repeat (2) @(negedge Clk);
    RST = 1'b1;
    set_req(0, 2, 0, 8'h00);
    set_req(1, 1, 2, 8'hA5);
    set_req(2, 3, 1, 8'h00);
`ifdef ARB_FIXED_PRIO_EN
    run_held(4, 0, 0, 0, 0);
`else
    run_held(4, 0, 1, 2, 0);
`endif

    do_cmd(1, 1, 3, 8'h77);
    // Abort in ISSUE: strobe still reaches the bank, but no ack.
    expect_cmd(1, 2, 3, 8'h00, 1'b0);
    set_req(1, 2, 3, 8'h00);
    @(negedge Clk);
    checks++;
    if (!busy) begin errors++; $display("FAIL busy_issue got %b required 1", busy); end
    RST = 1'b0;
    req = '0;
    @(negedge Clk);
    checks++;
    if (busy || ack != '0) begin errors++; $display("FAIL abort got busy=%b ack=%b required 0 0", busy, ack); end
    RST = 1'b1;
    set_req(0, 3, 1, 8'h00);
    set_req(2, 2, 4, 8'h00);
`ifdef ARB_FIXED_PRIO_EN
    run_held(2, 0, 0, 0, 0);
`else
    run_held(2, 0, 2, 0, 0);
`endif

    for (int i = 0; i < 50; i++)
      do_cmd(int'($urandom_range(0, NREQ-1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)), W'($urandom));

    repeat (3) @(negedge Clk);
    checks++;
    if (stb_q.size() != 0 || ack_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending strobes=%0d acks=%0d required 0 0", stb_q.size(), ack_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
